// File: rtl/fxp_pkg.sv
// Shared constants and helpers for the fixed-point arithmetic group.
// Narrowing mode encodings plus a width helper for guard/product sizing.
package fxp_pkg;

    localparam int RND_TRUNC      = 0;
    localparam int RND_HALF_UP    = 1;
    localparam int RND_CONVERGENT = 2;

    function automatic int fxp_max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Narrows a full-precision signed product to WIO.WFO with rounding and overflow flag.
// Latency: combinational. Backpressure: none, pure function of p.
// Overflow behaviour: clamp when FXP_MULT_SAT_EN is defined, else sign-preserving truncation.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int WI       = 6,
    parameter int WF       = 8,
    parameter int WIO      = 4,
    parameter int WFO      = 4,
    parameter int RND_MODE = RND_TRUNC
) (
    input  logic signed [WI+WF-1:0]   p,
    output logic        [WIO+WFO-1:0] o,
    output logic                      ovf
);

    localparam int IW = fxp_max_w(WI + 1, WIO);
    localparam int EW = IW + WF;
    localparam int RW = IW + WFO;
    localparam int OW = WIO + WFO;
    localparam int D  = WF - WFO;
    localparam logic [OW-1:0] SAT_MIN = OW'(1) << (OW - 1);
    localparam logic [OW-1:0] SAT_MAX = ~SAT_MIN;

    logic signed [EW-1:0] ext;
    logic        [RW-1:0] r;
    logic        [RW-OW:0] top;

    // One extra integer bit above the product so a rounding carry is kept.
    assign ext = EW'(p);

    generate
        if (D > 0) begin : g_drop
            localparam logic [EW-1:0] HALF = EW'(1) << (D - 1);
            logic [EW-1:0] inc;
            logic [EW-1:0] sum;
            logic          unused_lsbs;
            if (RND_MODE == RND_HALF_UP) begin : g_half
                assign inc = HALF;
            end else if (RND_MODE == RND_CONVERGENT) begin : g_conv
                // Half-minus-one plus kept LSB: an exact half only carries when the LSB is odd.
                assign inc = HALF - EW'(1) + EW'(p[D]);
            end else begin : g_trunc
                assign inc = '0;
            end
            assign sum         = ext + inc;
            assign r           = sum[EW-1:D];
            assign unused_lsbs = ^sum[D-1:0];
        end else if (D == 0) begin : g_keep
            assign r = ext;
        end else begin : g_pad
            assign r = {ext, {(-D){1'b0}}};
        end
    endgenerate

    assign top = r[RW-1:OW-1];
    assign ovf = !((&top) || !(|top));

    always_comb begin
        o = r[OW-1:0];
        if (ovf) begin
`ifdef FXP_MULT_SAT_EN
            o = p[WI+WF-1] ? SAT_MIN : SAT_MAX;
`else
            o = (r[OW-1:0] & SAT_MAX) | (p[WI+WF-1] ? SAT_MIN : '0);
`endif
        end
    end

endmodule

// File: rtl/fxp_mult_pipe.sv
// Signed fixed-point multiplier, narrowed to WIO.WFO; FXP_MULT_SAT_EN selects clamping on overflow.
// Latency: STAGES cycles, one result per cycle.
// Backpressure: single global advance; a stalled output freezes every stage and drops in_ready.
module fxp_mult_pipe
    import fxp_pkg::*;
#(
    parameter int WI1      = 4,
    parameter int WF1      = 3,
    parameter int WI2      = 2,
    parameter int WF2      = 5,
    parameter int WIO      = 4,
    parameter int WFO      = 4,
    parameter int STAGES   = 3,
    parameter int RND_MODE = RND_TRUNC
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [WI1+WF1-1:0] in1,
    input  logic signed [WI2+WF2-1:0] in2,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic        [WIO+WFO-1:0] out,
    output logic                      out_ovf
);

    localparam int PW = WI1 + WF1 + WI2 + WF2;
    localparam int NP = STAGES - 1;

    logic signed [PW-1:0]      a_ext;
    logic signed [PW-1:0]      b_ext;
    logic signed [PW-1:0]      prod;
    logic signed [PW-1:0]      p_q [NP];
    logic        [NP-1:0]      v_q;
    logic                      adv;
    logic        [WIO+WFO-1:0] nar;
    logic                      nar_ovf;

    assign a_ext    = PW'(in1);
    assign b_ext    = PW'(in2);
    assign prod     = a_ext * b_ext;
    assign adv      = out_ready | ~out_valid;
    assign in_ready = adv;

    fxp_round_sat #(
        .WI       (WI1 + WI2),
        .WF       (WF1 + WF2),
        .WIO      (WIO),
        .WFO      (WFO),
        .RND_MODE (RND_MODE)
    ) u_round (
        .p   (p_q[NP-1]),
        .o   (nar),
        .ovf (nar_ovf)
    );

    // Stage 0 holds the raw product; later product stages are plain delays for retiming.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NP; i++) begin
                p_q[i] <= '0;
            end
            v_q       <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            out_ovf   <= 1'b0;
        end else if (adv) begin
            p_q[0] <= prod;
            v_q[0] <= in_valid;
            for (int i = 1; i < NP; i++) begin
                p_q[i] <= p_q[i-1];
                v_q[i] <= v_q[i-1];
            end
            out_valid <= v_q[NP-1];
            out       <= nar;
            out_ovf   <= nar_ovf;
        end
    end

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// Scoreboard bench: three DUTs (one per rounding mode) share stimulus and handshakes.
module tb_fxp_mult_pipe;

    typedef struct packed {
        logic [2:0][7:0] o;
        logic [2:0]      v;
    } exp_t;

`ifdef FXP_MULT_SAT_EN
    localparam logic [7:0] E6 = 8'h7F, E8 = 8'h7F, E9 = 8'h80;
`else
    localparam logic [7:0] E6 = 8'h00, E8 = 8'h00, E9 = 8'hFC;
`endif

    logic       CLK, RST, in_valid, out_ready;
    logic [6:0] in1, in2;
    logic [2:0] rdy, vld, ovf;
    logic [7:0] o0, o1, o2;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    fxp_mult_pipe #(.RND_MODE(0)) dut0 (.CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdy[0]),
        .in1(in1), .in2(in2), .out_valid(vld[0]), .out_ready(out_ready), .out(o0), .out_ovf(ovf[0]));
    fxp_mult_pipe #(.RND_MODE(1)) dut1 (.CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdy[1]),
        .in1(in1), .in2(in2), .out_valid(vld[1]), .out_ready(out_ready), .out(o1), .out_ovf(ovf[1]));
    fxp_mult_pipe #(.RND_MODE(2)) dut2 (.CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(rdy[2]),
        .in1(in1), .in2(in2), .out_valid(vld[2]), .out_ready(out_ready), .out(o2), .out_ovf(ovf[2]));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    function automatic exp_t mk(input logic [7:0] e0, e1, e2, input logic v0, v1, v2);
        exp_t e;
        e.o = {e2, e1, e0};
        e.v = {v2, v1, v0};
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Monitor: pops one expectation per output handshake.
    always @(negedge CLK) begin
        if (RST && vld[0] && out_ready) begin
            exp_t e;
            chk("valid_align", {29'd0, vld}, 32'h7);
            if (sb.size() == 0) begin
                chk("unexpected_output", {24'd0, o0}, 32'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("out_mode0", {24'd0, o0}, {24'd0, e.o[0]});
                chk("out_mode1", {24'd0, o1}, {24'd0, e.o[1]});
                chk("out_mode2", {24'd0, o2}, {24'd0, e.o[2]});
                chk("ovf", {29'd0, ovf}, {29'd0, e.v});
            end
        end
    end

    task automatic send(input logic [6:0] a, input logic [6:0] b, input exp_t e);
        int tries = 0;
        in_valid = 1'b1;
        in1      = a;
        in2      = b;
        forever begin
            @(negedge CLK);
            if (rdy[0]) begin
                sb.push_back(e);
                break;
            end
            tries++;
            if (tries > 50) begin
                chk("send_timeout", 32'd0, 32'd1);
                break;
            end
            @(posedge CLK);
            #1;
        end
        @(posedge CLK);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic lat_send(input logic [6:0] a, input logic [6:0] b, input exp_t e);
        int n = 0;
        in_valid = 1'b1;
        in1      = a;
        in2      = b;
        @(negedge CLK);
        chk("lat_in_ready", {31'd0, rdy[0]}, 32'd1);
        sb.push_back(e);
        do begin
            @(posedge CLK);
            #1;
            in_valid = 1'b0;
            n++;
            @(negedge CLK);
        end while (!vld[0] && n < 10);
        chk("latency", n, 32'd3);
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (sb.size() == 0) break;
        end
        chk("drain_empty", sb.size(), 32'd0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [7:0] held;
        RST       = 1'b0;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_valid", {29'd0, vld}, 32'd0);
        chk("reset_out", {o2, o1, o0}, 32'd0);
        chk("reset_ovf", {29'd0, ovf}, 32'd0);
        RST = 1'b1;
        #1;
        chk("ready_after_reset", {29'd0, rdy}, 32'h7);
        @(posedge CLK);
        #1;

        // 2.5 * 1.25 = 3.125
        lat_send(7'h14, 7'h28, mk(8'h32, 8'h32, 8'h32, 0, 0, 0));

        send(7'h01, 7'h08, mk(8'h00, 8'h01, 8'h00, 0, 0, 0));
        send(7'h03, 7'h08, mk(8'h01, 8'h02, 8'h02, 0, 0, 0));
        send(7'h7F, 7'h08, mk(8'hFF, 8'h00, 8'h00, 0, 0, 0));
        send(7'h7D, 7'h08, mk(8'hFE, 8'hFF, 8'hFE, 0, 0, 0));
        send(7'h40, 7'h40, mk(E6, E6, E6, 1, 1, 1));
        send(7'h40, 7'h20, mk(8'h80, 8'h80, 8'h80, 0, 0, 0));
        send(7'h33, 7'h28, mk(8'h7F, E8, E8, 0, 1, 1));
        send(7'h40, 7'h21, mk(E9, E9, E9, 1, 1, 1));
        drain();

        // Back-to-back stream with a 6-cycle output stall.
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    send(7'(i + 1), 7'h10, mk(8'(i + 1), 8'(i + 1), 8'(i + 1), 0, 0, 0));
                end
            end
            begin
                repeat (4) @(posedge CLK);
                #1;
                out_ready = 1'b0;
                @(negedge CLK);
                held = o0;
                for (int c = 0; c < 6; c++) begin
                    if (c > 0) @(negedge CLK);
                    chk("stall_in_ready", {29'd0, rdy}, 32'd0);
                    chk("stall_valid", {31'd0, vld[0]}, 32'd1);
                    chk("stall_hold", {24'd0, o0}, {24'd0, held});
                    @(posedge CLK);
                    #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three samples in flight.
        send(7'h10, 7'h10, mk(8'h10, 8'h10, 8'h10, 0, 0, 0));
        send(7'h11, 7'h10, mk(8'h11, 8'h11, 8'h11, 0, 0, 0));
        send(7'h12, 7'h10, mk(8'h12, 8'h12, 8'h12, 0, 0, 0));
        chk("pre_reset_valid", {31'd0, vld[0]}, 32'd1);
        RST = 1'b0;
        sb.delete();
        #1;
        chk("midreset_valid", {29'd0, vld}, 32'd0);
        chk("midreset_out", {o2, o1, o0}, 32'd0);
        chk("midreset_ovf", {29'd0, ovf}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("ready_after_midreset", {29'd0, rdy}, 32'h7);
        repeat (5) @(posedge CLK);
        #1;
        lat_send(7'h15, 7'h10, mk(8'h15, 8'h15, 8'h15, 0, 0, 0));
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
